sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that reads the 2-word system-ID slave (word 0 = ID, word 1 = build timestamp) and compares both words against expected values.
- Runs once after reset, and again on each `start` pulse.
- Sits beside the Nios/Qsys fabric. Its `pass`/`fail` outputs gate the stepper-motor enable logic so a mismatched bitstream/software pair never drives coils.

Parameters:
- `ADDR_W`, 32, master byte-address width.
- `BASE_ADDR`, 32'h0000_0000, byte address of sysid word 0; word 1 is at `BASE_ADDR + 4`.
- `EXPECTED_ID`, 32'h0400_0000, required value of word 0.
- `EXPECTED_TS`, 32'h544F_5EA8, required value of word 1.
- `TIMEOUT_CYCLES`, 255, maximum cycles from read issue to `readdatavalid` (only with timeout feature).

Ports:
- `clock` in 1 system clock
- `reset` in 1 synchronous, active-high reset
- `start` in 1 single-cycle request to re-run the check; ignored unless idle/done
- `avm_address` out `ADDR_W` read byte address
- `avm_read` out 1 read strobe
- `avm_waitrequest` in 1 slave stall
- `avm_readdata` in 32 read data
- `avm_readdatavalid` in 1 read data valid (pipelined read, variable latency ≥1)
- `busy` out 1 check in progress
- `done` out 1 check finished (level, held until next run)
- `pass` out 1 both words matched (valid when `done`)
- `fail` out 1 mismatch or timeout (valid when `done`)
- `timeout` out 1 sticky: last run aborted on timeout
- `id_value` out 32 captured word 0
- `ts_value` out 32 captured word 1

Behaviour:
- Reset: all outputs 0; `avm_address` = `BASE_ADDR`; state = `ISSUE_ID`, so the check auto-runs on the first cycle after `reset` deasserts.
- States:
  - `IDLE`: `start` → `ISSUE_ID`.
  - `ISSUE_ID`: `avm_read` = 1, address = `BASE_ADDR`, held while `avm_waitrequest`; accepted (read & !waitrequest) → `WAIT_ID`.
  - `WAIT_ID`: on `avm_readdatavalid`, capture `id_value` → `ISSUE_TS`.
  - `ISSUE_TS`: `avm_read` = 1, address = `BASE_ADDR + 4`, same waitrequest rule → `WAIT_TS`.
  - `WAIT_TS`: on `readdatavalid`, capture `ts_value` → `DONE`.
  - `DONE`: `start` → `ISSUE_ID`.
- Entering `ISSUE_ID` from `IDLE` or `DONE`: clear `done`, `pass`, `fail`, `timeout`; captured values are retained until overwritten.
- Read discipline: `avm_read` and `avm_address` stable while `waitrequest` = 1. Exactly one outstanding read. `readdatavalid` is ignored outside the WAIT states.
- `readdatavalid` in the same cycle the read is accepted is not legal for this slave class; it is ignored.
- Result is registered on entry to `DONE`:
  - `pass` = (`id_value` == `EXPECTED_ID`) && (`ts_value` == `EXPECTED_TS`).
  - `fail` = !`pass`.
  - `done` = 1.
- `busy` = 1 in `ISSUE_*` and `WAIT_*`.
- Minimum run latency with a zero-wait, latency-1 slave: 4 cycles from `start` (or from reset release) to `done` = 1.
- `start` while busy: ignored, no queueing.
- `reset` mid-transaction: abort immediately, drop `avm_read`, restart per the reset values. Any in-flight `readdatavalid` that arrives in `ISSUE_ID` is ignored.

Optional Feature:
- Macro: `SYSID_CHECKER_TIMEOUT_EN`.
- Defined:
  - An 8..16-bit counter (width from `TIMEOUT_CYCLES`) clears on entry to each `ISSUE` state and counts in `ISSUE_*`/`WAIT_*`.
  - Reaching `TIMEOUT_CYCLES` → drop `avm_read`, set `timeout` = 1, `fail` = 1, `pass` = 0, `done` = 1 → `DONE`.
  - A late `readdatavalid` arriving in `DONE` is ignored.
- Undefined: no counter; the FSM waits indefinitely; `timeout` is tied to 0.

Decomposition:
- Package `sysid_pkg`:
  - state enum `sysid_state_t`;
  - word offset constants `SYSID_OFS_ID` = 0 and `SYSID_OFS_TS` = 4;
  - default `EXPECTED_ID`/`EXPECTED_TS` constants.
- No sub-module required. The timeout counter stays inline under the macro.

Test Plan:
- Zero-wait slave, latency 1, returns 32'h0400_0000 / 32'h544F_5EA8 → after reset release, `done` = 1 on cycle 4, `pass` = 1, `fail` = 0, addresses seen 0x0 then 0x4.
- Slave returns ID 32'h0400_0001 → `done` = 1, `pass` = 0, `fail` = 1, `id_value` = 32'h0400_0001.
- `waitrequest` held 3 cycles on each read, `readdatavalid` latency 5 → `avm_read`/`avm_address` stable during stall, exactly 2 accepted reads, `pass` = 1.
- `start` pulsed while busy, then again in `DONE` → first ignored; second clears `done` next cycle and a fresh 2-read sequence occurs.
- `reset` asserted during `WAIT_TS` → outputs return to 0 next cycle, check restarts at address 0x0 after release.
- With `SYSID_CHECKER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, slave never asserts `readdatavalid` → `done` = 1, `timeout` = 1, `fail` = 1, `avm_read` = 0, cycle count matches 16.

Source files
------------

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared states, word offsets and defaults for the sysid checker
package sysid_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE_ID, WAIT_ID, ISSUE_TS, WAIT_TS, DONE} sysid_state_t;
  localparam logic [31:0] SYSID_OFS_ID = 32'd0;
  localparam logic [31:0] SYSID_OFS_TS = 32'd4;
  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0400_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h544F_5EA8;
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return w < 8 ? 8 : w > 16 ? 16 : w;
  endfunction
endpackage

// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid ID/timestamp over Avalon-MM and flags pass/fail
// Optional read timeout enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter int          ADDR_W         = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);
  localparam logic [ADDR_W-1:0] ADDR_ID = ADDR_W'(BASE_ADDR + SYSID_OFS_ID);
  localparam logic [ADDR_W-1:0] ADDR_TS = ADDR_W'(BASE_ADDR + SYSID_OFS_TS);
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  sysid_state_t state, state_d;
  logic restart, ok, tmo;
  assign restart = (state == IDLE || state == DONE) && start;
  assign ok = id_value == EXPECTED_ID && avm_readdata == EXPECTED_TS;
  // reset gates the strobes so the bus is quiet the moment reset asserts
  assign avm_read = !reset && (state == ISSUE_ID || state == ISSUE_TS);
  assign busy = !reset && (state == ISSUE_ID || state == WAIT_ID || state == ISSUE_TS || state == WAIT_TS);
  assign avm_address = state == ISSUE_TS ? ADDR_TS : ADDR_ID;
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: state_d = start ? ISSUE_ID : state;
      ISSUE_ID:   state_d = avm_waitrequest ? ISSUE_ID : WAIT_ID;
      WAIT_ID:    state_d = avm_readdatavalid ? ISSUE_TS : WAIT_ID;
      ISSUE_TS:   state_d = avm_waitrequest ? ISSUE_TS : WAIT_TS;
      WAIT_TS:    state_d = avm_readdatavalid ? DONE : WAIT_TS;
      default:    state_d = IDLE;
    endcase
    if (tmo) state_d = DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ISSUE_ID;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state <= state_d;
      if (restart) {done, pass, fail} <= '0;
      if (state == WAIT_ID && avm_readdatavalid) id_value <= avm_readdata;
      if (state == WAIT_TS && avm_readdatavalid) begin
        ts_value <= avm_readdata;
        done     <= 1'b1;
        pass     <= ok;
        fail     <= !ok;
      end
      if (tmo) {done, pass, fail} <= 3'b101;
    end
  end
`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  logic timeout_q;
  assign tmo = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign timeout = timeout_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt       <= (state_d != state && (state_d == ISSUE_ID || state_d == ISSUE_TS)) ? '0 : busy ? cnt + 1'b1 : cnt;
      timeout_q <= tmo | (timeout_q & !restart);
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed vectors against a behavioural sysid slave
module tb_sysid_checker;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] avm_address, avm_readdata = '0, id_value, ts_value;
  logic avm_read, avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic busy, done, pass, fail, timeout;
  always #5 clk = ~clk;

  sysid_checker #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clk), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  int ntests = 0, nfail = 0, cur = -1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s (case %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  // slave model: ws stall cycles per read, lat cycles to readdatavalid
  logic [31:0] id_ret, ts_ret, pend_data, held_addr;
  logic [31:0] addr_log [8];
  int ws = 0, lat = 1, pend = 0, stall = 0, n_acc = 0;
  logic never_valid = 1'b0, held = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (reset) begin
        pend = 0; stall = 0; held = 1'b0; avm_waitrequest = 1'b0;
        continue;
      end
      if (held) begin
        chk("stall_read_held", {31'd0, avm_read}, 32'd1);
        chk("stall_addr_held", avm_address, held_addr);
      end
      held = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !never_valid) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = pend_data;
        end
      end
      if (avm_read) begin
        if (stall < ws) begin
          avm_waitrequest = 1'b1; stall++; held = 1'b1; held_addr = avm_address;
        end else begin
          avm_waitrequest = 1'b0; stall = 0;
          if (n_acc < 8) addr_log[n_acc] = avm_address;
          n_acc++;
          pend = lat;
          pend_data = avm_address == 32'h4 ? ts_ret : id_ret;
        end
      end else begin
        avm_waitrequest = 1'b0; stall = 0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_addr", avm_address, 32'h0);
    chk("rst_id", id_value, 32'h0);
    n_acc = 0;
    reset = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] id, ts;
    int ws, lat, cyc;
    logic pass;
  } vec_t;
  vec_t vecs [6];
  int cyc;

  initial begin
    vecs[0] = '{32'h0400_0000, 32'h544F_5EA8, 0, 1, 4, 1'b1};
    vecs[1] = '{32'h0400_0001, 32'h544F_5EA8, 0, 1, 4, 1'b0};
    vecs[2] = '{32'h0400_0000, 32'h544F_5EA9, 0, 1, 4, 1'b0};
    vecs[3] = '{32'h0400_0000, 32'h544F_5EA8, 3, 5, 18, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1, 2, 8, 1'b0};
    vecs[5] = '{32'h0400_0000, 32'h544F_5EA8, 2, 1, 8, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cur = i;
      id_ret = vecs[i].id; ts_ret = vecs[i].ts; ws = vecs[i].ws; lat = vecs[i].lat;
      do_reset();
      wait_done(cyc);
      chk("cycles", cyc, vecs[i].cyc);
      chk("pass", {31'd0, pass}, {31'd0, vecs[i].pass});
      chk("fail", {31'd0, fail}, {31'd0, !vecs[i].pass});
      chk("id_value", id_value, vecs[i].id);
      chk("ts_value", ts_value, vecs[i].ts);
      chk("accepted_reads", n_acc, 32'd2);
      chk("addr0", addr_log[0], 32'h0);
      chk("addr1", addr_log[1], 32'h4);
      chk("busy_in_done", {31'd0, busy}, 32'd0);
      chk("read_in_done", {31'd0, avm_read}, 32'd0);
    end

    // start while busy is ignored; start in DONE reruns
    cur = 10;
    n_acc = 0;
    pulse_start();
    chk("start_clears_done", {31'd0, done}, 32'd0);
    chk("start_sets_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    pulse_start();
    wait_done(cyc);
    repeat (6) @(posedge clk);
    #1;
    chk("rerun_reads", n_acc, 32'd2);
    chk("rerun_done_held", {31'd0, done}, 32'd1);
    chk("rerun_pass", {31'd0, pass}, 32'd1);
    chk("rerun_addr0", addr_log[0], 32'h0);
    chk("rerun_addr1", addr_log[1], 32'h4);

    // reset during WAIT_TS aborts and restarts at word 0
    cur = 11;
    ws = 0; lat = 5;
    do_reset();
    cyc = 0;
    while (n_acc < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_wait_ts", n_acc, 32'd2);
    chk("wait_ts_not_done", {31'd0, done}, 32'd0);
    do_reset();
    wait_done(cyc);
    chk("restart_cycles", cyc, 32'd12);
    chk("restart_addr0", addr_log[0], 32'h0);
    chk("restart_reads", n_acc, 32'd2);
    chk("restart_pass", {31'd0, pass}, 32'd1);

    // slave that never returns data
    cur = 12;
    lat = 1; never_valid = 1'b1;
    do_reset();
`ifdef SYSID_CHECKER_TIMEOUT_EN
    wait_done(cyc);
    chk("tmo_cycles", cyc, 32'd16);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    chk("tmo_fail", {31'd0, fail}, 32'd1);
    chk("tmo_pass", {31'd0, pass}, 32'd0);
    chk("tmo_read", {31'd0, avm_read}, 32'd0);
    never_valid = 1'b0;
    pulse_start();
    chk("tmo_cleared", {31'd0, timeout}, 32'd0);
    wait_done(cyc);
    chk("tmo_recover_pass", {31'd0, pass}, 32'd1);
`else
    repeat (40) @(posedge clk);
    #1;
    chk("hang_not_done", {31'd0, done}, 32'd0);
    chk("hang_busy", {31'd0, busy}, 32'd1);
    chk("hang_timeout", {31'd0, timeout}, 32'd0);
    chk("hang_reads", n_acc, 32'd1);
    never_valid = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
